// File: rtl/seg7_scan_drv.sv
// Multiplexed common-anode seven-segment scan driver with double-buffered data,
// blanking, decimal points and leading-zero suppression. Optional blink: SEG7_BLINK_EN.
module seg7_scan_drv #(
   parameter int NUM_DIGITS   = 8,
   parameter int SCAN_DIV     = 32768
`ifdef SEG7_BLINK_EN
   ,
   parameter int BLINK_FRAMES = 64
`endif
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    disp_mode,
   input  logic [NUM_DIGITS*8-1:0] i_data,
   input  logic                    i_load,
   input  logic [NUM_DIGITS-1:0]   i_dp,
   input  logic [NUM_DIGITS-1:0]   i_blank,
   input  logic                    i_lzs,
`ifdef SEG7_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   i_blink,
`endif
   output logic [7:0]              o_seg,
   output logic [NUM_DIGITS-1:0]   o_sel,
   output logic                    o_frame_done
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int AW = $clog2(NUM_DIGITS);
   localparam int DW = NUM_DIGITS * 8;
   localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
   localparam logic [AW-1:0] ADDR_MAX = AW'(NUM_DIGITS - 1);

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [DW-1:0]         pend_q, pend_d;
   logic                  pend_vld_q, pend_vld_d;
   logic [DW-1:0]         shadow_q, shadow_d;
   logic [7:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] sel_q, sel_d;
   logic                  fd_q, fd_d;

   logic                  tick, wrap;
   logic                  blink_kill;
   logic [NUM_DIGITS-1:0] supp_vec;
   logic                  tail;
   logic [7:0]            raw_byte;
   logic [3:0]            nib;
   logic                  dp_bit, blank_bit, supp_bit;

   function automatic logic [7:0] hex_glyph(input logic [3:0] n);
      case (n)
         4'h0: hex_glyph = 8'hC0;
         4'h1: hex_glyph = 8'hF9;
         4'h2: hex_glyph = 8'hA4;
         4'h3: hex_glyph = 8'hB0;
         4'h4: hex_glyph = 8'h99;
         4'h5: hex_glyph = 8'h92;
         4'h6: hex_glyph = 8'h82;
         4'h7: hex_glyph = 8'hF8;
         4'h8: hex_glyph = 8'h80;
         4'h9: hex_glyph = 8'h90;
         4'hA: hex_glyph = 8'h88;
         4'hB: hex_glyph = 8'h83;
         4'hC: hex_glyph = 8'hC6;
         4'hD: hex_glyph = 8'hA1;
         4'hE: hex_glyph = 8'h86;
         default: hex_glyph = 8'h8E;
      endcase
   endfunction

   assign tick = (cnt_q == CNT_MAX);
   assign wrap = tick && (addr_q == ADDR_MAX);

   // Scan timing and buffering; a load in the wrap cycle lands in pending, not shadow.
   always_comb begin
      cnt_d      = tick ? '0 : cnt_q + CW'(1);
      addr_d     = addr_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      shadow_d   = shadow_q;
      fd_d       = wrap;
      if (tick) addr_d = wrap ? '0 : addr_q + AW'(1);
      if (wrap && pend_vld_q) begin
         shadow_d   = pend_q;
         pend_vld_d = 1'b0;
      end
      if (i_load) begin
         pend_d     = i_data;
         pend_vld_d = 1'b1;
      end
   end

   // Suppression mask: digit k is a leading zero if it and every higher digit is 0 with no dp.
   always_comb begin
      supp_vec = '0;
      tail     = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         tail        = tail & (shadow_q[4*k +: 4] == 4'h0) & ~i_dp[k];
         supp_vec[k] = tail;
      end
   end

   always_comb begin
      raw_byte  = 8'hFF;
      nib       = 4'h0;
      dp_bit    = 1'b0;
      blank_bit = 1'b0;
      supp_bit  = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (AW'(k) == addr_q) begin
            raw_byte  = shadow_q[8*k +: 8];
            nib       = shadow_q[4*k +: 4];
            dp_bit    = i_dp[k];
            blank_bit = i_blank[k];
            supp_bit  = supp_vec[k];
         end
      end
   end

`ifdef SEG7_BLINK_EN
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          phase_q, phase_d;
   logic          blink_sel;

   always_comb begin
      bcnt_d    = bcnt_q;
      phase_d   = phase_q;
      blink_sel = 1'b0;
      if (wrap) begin
         if (bcnt_q == BLINK_MAX) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d = bcnt_q + BW'(1);
         end
      end
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (AW'(k) == addr_q) blink_sel = i_blink[k];
      end
   end

   assign blink_kill = ~phase_q & blink_sel;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bcnt_q  <= '0;
         phase_q <= 1'b1;
      end else begin
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
      end
   end
`else
   assign blink_kill = 1'b0;
`endif

   always_comb begin
      sel_d = ~(NUM_DIGITS'(1) << addr_q);
      seg_d = 8'hFF;
      if (blank_bit || blink_kill) begin
         seg_d = 8'hFF;
      end else if (disp_mode) begin
         seg_d = raw_byte;
      end else if (i_lzs && (addr_q != '0) && supp_bit) begin
         seg_d = 8'hFF;
      end else begin
         seg_d = hex_glyph(nib) & {~dp_bit, 7'h7F};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q      <= '0;
         addr_q     <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         shadow_q   <= '0;
         seg_q      <= 8'hFF;
         sel_q      <= '1;
         fd_q       <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         shadow_q   <= shadow_d;
         seg_q      <= seg_d;
         sel_q      <= sel_d;
         fd_q       <= fd_d;
      end
   end

   assign o_seg        = seg_q;
   assign o_sel        = sel_q;
   assign o_frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Bench for seg7_scan_drv: 8 digits, 4 clocks per digit; expected frames are queued
// by the driver and popped by a monitor each time a new digit select appears.
module tb_seg7_scan_drv;

   localparam int ND = 8;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        disp_mode = 1'b0;
   logic [63:0] i_data = '0;
   logic        i_load = 1'b0;
   logic [7:0]  i_dp = '0;
   logic [7:0]  i_blank = '0;
   logic        i_lzs = 1'b0;
   logic [7:0]  o_seg;
   logic [7:0]  o_sel;
   logic        o_frame_done;
`ifdef SEG7_BLINK_EN
   logic [7:0]  i_blink = '0;
`endif

   always #5 clk = ~clk;

`ifdef SEG7_BLINK_EN
   seg7_scan_drv #(.NUM_DIGITS(ND), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
      .clk(clk), .rstn(rstn), .disp_mode(disp_mode), .i_data(i_data), .i_load(i_load),
      .i_dp(i_dp), .i_blank(i_blank), .i_lzs(i_lzs), .i_blink(i_blink),
      .o_seg(o_seg), .o_sel(o_sel), .o_frame_done(o_frame_done));
`else
   seg7_scan_drv #(.NUM_DIGITS(ND), .SCAN_DIV(4)) dut (
      .clk(clk), .rstn(rstn), .disp_mode(disp_mode), .i_data(i_data), .i_load(i_load),
      .i_dp(i_dp), .i_blank(i_blank), .i_lzs(i_lzs),
      .o_seg(o_seg), .o_sel(o_sel), .o_frame_done(o_frame_done));
`endif

   int tests_run = 0;
   int tests_failed = 0;
   logic [15:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one expected {sel,seg} per new digit period; frame_done cadence.
   logic [7:0]  last_sel = 8'hFF;
   logic [15:0] mon_e;
   int cyc = 0;
   int last_fd = -1;

   always @(negedge clk) begin
      cyc++;
      if (!rstn) begin
         last_fd  = -1;
         last_sel = 8'hFF;
      end else begin
         if (o_sel !== last_sel && o_sel !== 8'hFF && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("digit_sel", {24'd0, o_sel}, {24'd0, mon_e[15:8]});
            check("digit_seg", {24'd0, o_seg}, {24'd0, mon_e[7:0]});
         end
         last_sel = o_sel;
         if (o_frame_done) begin
            check("fd_on_last_digit", {24'd0, o_sel}, 32'h7F);
            if (last_fd >= 0) check("fd_period", cyc - last_fd, 32);
            last_fd = cyc;
         end
      end
   end

   task automatic push_frame(input logic [63:0] segs);
      for (int k = 0; k < ND; k++) begin
         exp_q.push_back({~(8'd1 << k), segs[8*k +: 8]});
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [63:0] d);
      i_data = d;
      i_load = 1'b1;
      @(negedge clk);
      i_load = 1'b0;
   endtask

   task automatic wait_fd();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (o_frame_done) seen = 1'b1;
      end
      check("frame_done_wait", {31'd0, seen}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_seg"}, {24'd0, o_seg}, 32'hFF);
      check({tag, "_sel"}, {24'd0, o_sel}, 32'hFF);
      check({tag, "_fd"}, {31'd0, o_frame_done}, 32'd0);
   endtask

   initial begin
      logic found;
      int nfr;
      #2 rstn = 1'b0;
      #1 check_reset_outputs("rst0");
      push_frame(64'hC0C0_C0C0_C0C0_C0C0);
      @(negedge clk);
      rstn = 1'b1;

      // Hex counting pattern
      idle(3);
      load(64'h0000_0000_7654_3210);
      wait_fd();
      push_frame(64'hF882_9299_B0A4_F9C0);

      // Leading-zero suppression, then a dp stops suppression at digit 3
      idle(2);
      load(64'h0000_0000_0000_00A0);
      wait_fd();
      i_lzs = 1'b1;
      push_frame(64'hFFFF_FFFF_FFFF_88C0);
      wait_fd();
      i_dp = 8'h08;
      push_frame(64'hFFFF_FFFF_40C0_88C0);

      // Raw mode with digit 2 blanked
      idle(2);
      load(64'h1716_1514_1312_1110);
      wait_fd();
      disp_mode = 1'b1;
      i_dp      = '0;
      i_lzs     = 1'b0;
      i_blank   = 8'h04;
      push_frame(64'h1716_1514_13FF_1110);

      // Two loads inside one frame: last wins, shown only in the next frame
      idle(6);
      load(64'h0000_0000_1111_1111);
      idle(8);
      load(64'h0000_0000_89AB_CDEF);
      wait_fd();
      disp_mode = 1'b0;
      i_blank   = '0;
      push_frame(64'h8090_8883_C6A1_868E);

      // Load in the exact wrap-tick cycle goes to pending
      idle(2);
      load(64'h0000_0000_2222_2222);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (o_sel == 8'h7F) found = 1'b1;
      end
      check("wrap_align", {24'd0, o_sel}, 32'h7F);
      idle(2);
      i_data = 64'h0000_0000_3333_3333;
      i_load = 1'b1;
      @(negedge clk);
      i_load = 1'b0;
      check("fd_after_wrap_load", {31'd0, o_frame_done}, 32'd1);
      push_frame(64'hA4A4_A4A4_A4A4_A4A4);
      wait_fd();
      push_frame(64'hB0B0_B0B0_B0B0_B0B0);
      wait_fd();

      // Mid-frame asynchronous reset discards a pending load
      idle(5);
      load(64'h0000_0000_4444_4444);
      idle(3);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1 check_reset_outputs("rst_mid");
`ifdef SEG7_BLINK_EN
      i_blink = 8'h01;
      nfr = 8;
      for (int f = 0; f < nfr; f++) begin
         if (((f / 2) % 2) == 1) push_frame(64'hC0C0_C0C0_C0C0_C0FF);
         else push_frame(64'hC0C0_C0C0_C0C0_C0C0);
      end
`else
      nfr = 2;
      for (int f = 0; f < nfr; f++) push_frame(64'hC0C0_C0C0_C0C0_C0C0);
`endif
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      for (int f = 0; f < nfr; f++) wait_fd();

      idle(2);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
